// File: rtl/mips_mdu.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO; 32 iterations per operation.
// Define MDU_DIV_EN to build the restoring divider (DIV/DIVU); otherwise divide requests are ignored.
module mips_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] S,
  input  logic [31:0] T,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = 6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state, w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [XLEN-1:0]   r_a, r_q, r_m;
  logic [XLEN-1:0]   r_hi, r_lo;
  logic              r_busy, r_done;
  logic              r_neg_lo;

  logic              w_op_ok, w_accept, w_last, w_mt;
  logic              w_signed, w_s_neg, w_t_neg;
  logic [XLEN-1:0]   w_s_mag, w_t_mag;
  logic [XLEN:0]     w_sum;
  logic [XLEN-1:0]   w_a_nx, w_q_nx;
  logic [PW-1:0]     w_prod;
  logic [XLEN-1:0]   w_hi_res, w_lo_res;

`ifdef MDU_DIV_EN
  logic              r_div, r_neg_hi;
  logic [XLEN:0]     w_shift, w_diff;
  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = ~op[1];
`endif

  // MULT and DIV (op[0]=0) work on magnitudes; signs are reapplied on the final edge
  assign w_signed = ~op[0];
  assign w_s_neg  = w_signed & S[XLEN-1];
  assign w_t_neg  = w_signed & T[XLEN-1];
  assign w_s_mag  = w_s_neg ? (~S + XLEN'(1)) : S;
  assign w_t_mag  = w_t_neg ? (~T + XLEN'(1)) : T;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state and control decode
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_mt       = 1'b0;
    case (r_state)
      IDLE: begin
        w_mt = ~start;
        if (start && w_op_ok) begin
          w_accept   = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CW'(XLEN - 1)) begin
          w_last     = 1'b1;
          w_state_nx = IDLE;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // One iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
  always_comb begin
    w_sum  = {1'b0, r_a} + (r_q[0] ? {1'b0, r_m} : '0);
    w_a_nx = w_sum[XLEN:1];
    w_q_nx = {w_sum[0], r_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
    w_shift = {r_a, r_q[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_m};
    if (r_div) begin
      w_a_nx = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      w_q_nx = {r_q[XLEN-2:0], ~w_diff[XLEN]};
    end
`endif
  end

  // Sign-corrected result from the last iteration, so HI/LO land on the final edge
  always_comb begin
    w_prod = {w_a_nx, w_q_nx};
    if (r_neg_lo) w_prod = ~w_prod + PW'(1);
    w_hi_res = w_prod[PW-1:XLEN];
    w_lo_res = w_prod[XLEN-1:0];
`ifdef MDU_DIV_EN
    if (r_div) begin
      w_hi_res = r_neg_hi ? (~w_a_nx + XLEN'(1)) : w_a_nx;
      w_lo_res = r_neg_lo ? (~w_q_nx + XLEN'(1)) : w_q_nx;
    end
`endif
  end

  // Datapath, counter, HI/LO and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MDU_DIV_EN
      r_div    <= 1'b0;
      r_neg_hi <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_nx == RUN);
      r_done <= w_last;
      if (w_accept) begin
        r_a      <= '0;
        r_q      <= w_s_mag;
        r_m      <= w_t_mag;
        r_cnt    <= '0;
        // a zero divisor yields an all-ones quotient that must not be negated
        r_neg_lo <= (w_s_neg ^ w_t_neg) & (|T);
`ifdef MDU_DIV_EN
        r_div    <= op[1];
        r_neg_hi <= w_s_neg;
`endif
      end else if (r_state == RUN) begin
        r_a   <= w_a_nx;
        r_q   <= w_q_nx;
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        if (w_last) begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
      end else if (w_mt) begin
        if (hi_we) r_hi <= S;
        if (lo_we) r_lo <= S;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
